// File: rtl/amo_responder.sv
// amo_responder: memory-side executor for RISC-V A-extension requests.
// Accepts one AMO/LR/SC request at a time, performs the read-modify-write
// on a word-addressed memory port and returns the old value or SC status.
// Holds the single load reservation used by LR/SC; external writes seen on
// the snoop port break it.
module amo_responder #(
   parameter int XLEN    = 64,
   parameter int PA_BITS = 34
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ReqValid,
   output logic                 ReqReady,
   input  logic [PA_BITS-1:0]   ReqAddr,
   input  logic [6:0]           ReqFunct7,
   input  logic [2:0]           ReqFunct3,
   input  logic [XLEN-1:0]      ReqWData,
   output logic                 MemReq,
   output logic                 MemWrite,
   output logic [PA_BITS-1:0]   MemAddr,
   output logic [XLEN-1:0]      MemWData,
   output logic [XLEN/8-1:0]    MemWStrb,
   input  logic                 MemAck,
   input  logic [XLEN-1:0]      MemRData,
   input  logic                 SnoopWrite,
   input  logic [PA_BITS-1:0]   SnoopAddr,
   output logic                 RespValid,
   input  logic                 RespReady,
   output logic [XLEN-1:0]      RespData
);

   localparam int STRB_W = XLEN / 8;
   // clears the byte offset inside one memory word
   localparam logic [PA_BITS-1:0] LINE_MASK = ~PA_BITS'(STRB_W - 1);

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SWAP = 5'b00001;
   localparam logic [4:0] OP_LR   = 5'b00010;
   localparam logic [4:0] OP_SC   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_OR   = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01100;
   localparam logic [4:0] OP_MIN  = 5'b10000;
   localparam logic [4:0] OP_MAX  = 5'b10100;
   localparam logic [4:0] OP_MINU = 5'b11000;
   localparam logic [4:0] OP_MAXU = 5'b11100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t               state_r;
   state_t               state_n;

   logic                 req_ready_r;
   logic                 mem_req_r;
   logic                 mem_write_r;
   logic                 resp_valid_r;
   logic [PA_BITS-1:0]   addr_r;
   logic [4:0]           funct5_r;
   logic                 word_r;
   logic                 lane_r;
   logic [XLEN-1:0]      rs2_r;
   logic [XLEN-1:0]      wdata_r;
   logic [STRB_W-1:0]    strb_r;
   logic [XLEN-1:0]      resp_data_r;
   logic                 resv_valid_r;
   logic [PA_BITS-1:0]   resv_addr_r;

   logic                 accept_s;
   logic [4:0]           req_op_s;
   logic                 req_word_s;
   logic                 req_lane_s;
   logic [PA_BITS-1:0]   req_line_s;
   logic [PA_BITS-1:0]   snoop_line_s;
   logic                 snoop_hit_s;
   logic                 sc_ok_s;
   logic                 sc_accept_s;
   logic                 read_done_s;
   logic                 lr_set_s;
   logic                 amo_done_s;
   logic [31:0]          rd_word_s;
   logic [XLEN-1:0]      old_ext_s;
   logic [XLEN-1:0]      opa_s;
   logic [XLEN-1:0]      opb_s;
   logic [XLEN-1:0]      new_s;
   logic [XLEN-1:0]      new_lane_s;
   logic [STRB_W-1:0]    new_strb_s;
   logic                 unused_s;

   // ---------------------------------------------------------------- helpers

   function automatic logic [PA_BITS-1:0] line_of(input logic [PA_BITS-1:0] a);
      return a & LINE_MASK;
   endfunction

   function automatic logic is_amo(input logic [4:0] op);
      logic r;
      case (op)
         OP_ADD, OP_SWAP, OP_XOR, OP_OR, OP_AND,
         OP_MIN, OP_MAX, OP_MINU, OP_MAXU: r = 1'b1;
         default:                          r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] w);
      logic [XLEN-1:0] r;
      r       = {XLEN{w[31]}};
      r[31:0] = w;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [31:0] w);
      return XLEN'(w);
   endfunction

   // places a 32-bit value into the selected half of the memory word
   function automatic logic [XLEN-1:0] place_word(input logic [31:0] w, input logic lane);
      return XLEN'(w) << {lane, 5'b00000};
   endfunction

   function automatic logic [STRB_W-1:0] lane_strb(input logic word, input logic lane);
      logic [STRB_W-1:0] r;
      if (word) begin
         r = STRB_W'(4'hF) << {lane, 2'b00};
      end else begin
         r = {STRB_W{1'b1}};
      end
      return r;
   endfunction

   // operands are pre-extended so one XLEN-wide compare serves both widths
   function automatic logic [XLEN-1:0] amo_alu(input logic [4:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
      logic            lt;
      logic [XLEN-1:0] r;
      lt = op[3] ? (a < b) : ($signed(a) < $signed(b));
      case (op)
         OP_SWAP:          r = b;
         OP_ADD:           r = a + b;
         OP_XOR:           r = a ^ b;
         OP_AND:           r = a & b;
         OP_OR:            r = a | b;
         OP_MIN, OP_MINU:  r = lt ? a : b;
         OP_MAX, OP_MAXU:  r = lt ? b : a;
         default:          r = a;
      endcase
      return r;
   endfunction

   // ------------------------------------------------------- request decode

   assign accept_s     = (state_r == ST_IDLE) && ReqValid;
   assign req_op_s     = ReqFunct7[6:2];
   assign req_word_s   = (XLEN == 32) || (ReqFunct3[1:0] != 2'b11);
   assign req_lane_s   = (XLEN == 64) ? ReqAddr[2] : 1'b0;
   assign req_line_s   = line_of(ReqAddr);
   assign snoop_line_s = line_of(SnoopAddr);
   assign snoop_hit_s  = SnoopWrite && resv_valid_r && (snoop_line_s == resv_addr_r);
   // a snoop landing in the same cycle as the SC already breaks the reservation
   assign sc_ok_s      = resv_valid_r && !snoop_hit_s && (resv_addr_r == req_line_s);
   assign unused_s     = ^{ReqFunct3[2], ReqFunct7[1:0]};

   // -------------------------------------------------------------- datapath

   // Extract the addressed lane of the read data and extend ALU operands.
   always_comb begin
      rd_word_s = 32'(MemRData >> {lane_r, 5'b00000});
      old_ext_s = MemRData;
      opa_s     = MemRData;
      opb_s     = rs2_r;
      if (word_r) begin
         old_ext_s = sext32(rd_word_s);
         if (funct5_r[3]) begin
            opa_s = zext32(rd_word_s);
            opb_s = zext32(rs2_r[31:0]);
         end else begin
            opa_s = sext32(rd_word_s);
            opb_s = sext32(rs2_r[31:0]);
         end
      end else begin
         old_ext_s = MemRData;
         opa_s     = MemRData;
         opb_s     = rs2_r;
      end
   end

   assign new_s = amo_alu(funct5_r, opa_s, opb_s);

   // Position the ALU result and strobes onto the memory word.
   always_comb begin
      new_lane_s = new_s;
      new_strb_s = lane_strb(word_r, lane_r);
      if (word_r) begin
         new_lane_s = place_word(new_s[31:0], lane_r);
      end else begin
         new_lane_s = new_s;
      end
   end

   // -------------------------------------------------------------- control

   // Next-state logic plus one-cycle event strobes for the datapath.
   always_comb begin
      state_n     = state_r;
      sc_accept_s = 1'b0;
      read_done_s = 1'b0;
      lr_set_s    = 1'b0;
      amo_done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (req_op_s == OP_SC) begin
                  sc_accept_s = 1'b1;
                  state_n     = sc_ok_s ? ST_WRITE : ST_RESP;
               end else begin
                  state_n = ST_READ;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_READ: begin
            if (MemAck) begin
               read_done_s = 1'b1;
               if (is_amo(funct5_r)) begin
                  state_n = ST_WRITE;
               end else begin
                  lr_set_s = (funct5_r == OP_LR);
                  state_n  = ST_RESP;
               end
            end else begin
               state_n = ST_READ;
            end
         end
         ST_WRITE: begin
            if (MemAck) begin
               amo_done_s = is_amo(funct5_r);
               state_n    = ST_RESP;
            end else begin
               state_n = ST_WRITE;
            end
         end
         ST_RESP: begin
            if (RespReady) begin
               state_n = ST_IDLE;
            end else begin
               state_n = ST_RESP;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State register and handshake outputs, registered from the next state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= ST_IDLE;
         req_ready_r  <= 1'b1;
         mem_req_r    <= 1'b0;
         mem_write_r  <= 1'b0;
         resp_valid_r <= 1'b0;
      end else begin
         state_r      <= state_n;
         req_ready_r  <= (state_n == ST_IDLE);
         mem_req_r    <= (state_n == ST_READ) || (state_n == ST_WRITE);
         mem_write_r  <= (state_n == ST_WRITE);
         resp_valid_r <= (state_n == ST_RESP);
      end
   end

   // Request capture, write data/strobes and response value.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_r      <= {PA_BITS{1'b0}};
         funct5_r    <= 5'b00000;
         word_r      <= 1'b0;
         lane_r      <= 1'b0;
         rs2_r       <= {XLEN{1'b0}};
         wdata_r     <= {XLEN{1'b0}};
         strb_r      <= {STRB_W{1'b0}};
         resp_data_r <= {XLEN{1'b0}};
      end else begin
         if (accept_s) begin
            addr_r   <= req_line_s;
            funct5_r <= req_op_s;
            word_r   <= req_word_s;
            lane_r   <= req_lane_s;
            rs2_r    <= ReqWData;
            if (req_op_s == OP_SC) begin
               wdata_r <= req_word_s ? place_word(ReqWData[31:0], req_lane_s) : ReqWData;
               strb_r  <= lane_strb(req_word_s, req_lane_s);
               if (sc_ok_s) begin
                  resp_data_r <= {XLEN{1'b0}};
               end else begin
                  resp_data_r <= {{(XLEN-1){1'b0}}, 1'b1};
               end
            end
         end else if (read_done_s) begin
            resp_data_r <= old_ext_s;
            wdata_r     <= new_lane_s;
            strb_r      <= new_strb_s;
         end
      end
   end

   // Load reservation: snoops and SC always break it, LR sets it, AMO writes
   // to the reserved word break it. A matching snoop beats a same-cycle LR.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resv_valid_r <= 1'b0;
         resv_addr_r  <= {PA_BITS{1'b0}};
      end else begin
         if (lr_set_s) begin
            resv_addr_r  <= addr_r;
            resv_valid_r <= !(SnoopWrite && (snoop_line_s == addr_r));
         end else if (snoop_hit_s) begin
            resv_valid_r <= 1'b0;
         end else if (sc_accept_s) begin
            resv_valid_r <= 1'b0;
         end else if (amo_done_s && (addr_r == resv_addr_r)) begin
            resv_valid_r <= 1'b0;
         end
      end
   end

   assign ReqReady  = req_ready_r;
   assign MemReq    = mem_req_r;
   assign MemWrite  = mem_write_r;
   assign MemAddr   = addr_r;
   assign MemWData  = wdata_r;
   assign MemWStrb  = strb_r;
   assign RespValid = resp_valid_r;
   assign RespData  = resp_data_r;

endmodule

// File: doc/amo_responder.md
Name: amo_responder

Overview:
- Memory-side responder for RISC-V A-extension requests: accepts one AMO/LR/SC request, performs read-modify-write against a simple word-addressed memory port, returns the original memory value (or SC status) to the requester.
- Sits between the uncore bus and on-chip SRAM/memory controller. Holds the single-hart load reservation for LR/SC.

Parameters:
- XLEN, 64, data width; 32 or 64.
- PA_BITS, 34, physical byte-address width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- ReqValid  in  1  request valid.
- ReqReady  out  1  responder can accept request.
- ReqAddr  in  PA_BITS  byte address; naturally aligned.
- ReqFunct7  in  7  AMO funct7; [6:2] selects op.
- ReqFunct3  in  3  width; [1:0]=10 word, 11 doubleword (XLEN=64 only).
- ReqWData  in  XLEN  rs2 operand, right-justified.
- MemReq  out  1  memory access request.
- MemWrite  out  1  1 write, 0 read.
- MemAddr  out  PA_BITS  XLEN-aligned address (low log2(XLEN/8) bits zero).
- MemWData  out  XLEN  write data, lane-positioned.
- MemWStrb  out  XLEN/8  byte strobes.
- MemAck  in  1  access complete this cycle; read data valid.
- MemRData  in  XLEN  read data.
- SnoopWrite  in  1  another agent wrote memory this cycle.
- SnoopAddr  in  PA_BITS  address of that write.
- RespValid  out  1  response valid.
- RespReady  in  1  requester accepts response.
- RespData  out  XLEN  old value (sign-extended for word) or SC status.

Behaviour:
- Reset (async, resetn=0): state IDLE, ReqReady=1, MemReq=0, MemWrite=0, RespValid=0, RespData=0, reservation invalid.
- States: IDLE -> READ -> WRITE -> RESP -> IDLE. Request captured on ReqValid&ReqReady in IDLE; ReqReady=1 only in IDLE.
- ReqFunct7[6:2]: 00001 swap, 00000 add, 00100 xor, 01100 and, 01000 or, 10000 min, 10100 max, 11000 minu, 11100 maxu, 00010 LR, 00011 SC. Other codes: treated as LR (read only, no write, no reservation change).
- READ: MemReq=1, MemWrite=0 held until MemAck; old value latched on MemAck. Word ops extract lane ReqAddr[2] (XLEN=64), sign-extend for compare/response.
- AMO ops: new = op(old, ReqWData) computed on 32 bits for word, XLEN for doubleword; signed/unsigned per funct7[5], min/max per funct7[4]. Goes WRITE; MemWData lane-positioned, MemWStrb=4 bytes of selected lane for word, all ones for doubleword. MemReq held until MemAck. RespData=old (sign-extended).
- LR: READ only, skips WRITE; sets reservation {valid, MemAddr}; RespData=old.
- SC: no READ. If reservation valid and matches MemAddr: WRITE ReqWData, RespData=0. Else: no memory access, RespData=1. Reservation cleared in both cases.
- Any AMO write clears a reservation matching its MemAddr. SnoopWrite with XLEN-aligned SnoopAddr matching reservation clears it, in any state; simultaneous LR set and matching snoop in same cycle: snoop wins (invalid).
- RESP: RespValid=1, RespData stable until RespValid&RespReady; then IDLE. Next request acceptable the cycle after handshake.
- Minimum latency, MemAck same cycle as MemReq: AMO 3 cycles request-to-RespValid, LR/SC-fail 2/1.
- MemAck ignored outside READ/WRITE. resetn asserted mid-operation aborts immediately; memory side must tolerate dropped MemReq.

Test Plan:
- XLEN=64, mem[0x100]=0x5, amoadd.d rs2=0x3 -> RespData=0x5, write 0x8, MemWStrb=0xFF.
- mem[0x104] word=0x80000000, amomin.w rs2=0x1 -> RespData=0xFFFFFFFF80000000, no change (old smaller); amominu.w rs2=0x1 -> writes 0x00000001, MemWStrb=0xF0.
- LR.d 0x200 then SC.d 0x200 rs2=0xAB -> LR returns mem value, SC RespData=0, mem=0xAB; second SC -> RespData=1, no MemReq.
- LR 0x200, SnoopWrite SnoopAddr=0x204 (same XLEN word), SC 0x200 -> RespData=1, no write.
- amoswap with MemAck delayed 5 cycles each phase and RespReady low 3 cycles -> MemReq held, RespData stable, ReqReady=0 throughout.
- resetn low during WRITE -> all outputs reset values at once, reservation invalid, next request serviced normally.
